sparse_scatter: RTL

SPARSE_SCATTER -- requirements
Module: sparse_scatter

---
 rtl/sparse_scatter_pkg.sv | 15 +
 rtl/sparse_scatter.sv | 108 ++++++++++
 2 files changed

// File: rtl/sparse_scatter_pkg.sv
// rtl/sparse_scatter_pkg.sv - shared state encoding and default sizes for the filter/scatter pair
package sparse_scatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEF_IL     = 4;
  localparam int DEF_FL     = 16;
  localparam int DEF_LENGTH = 32;
  localparam int DEF_NNZ    = 16;

endpackage

// File: rtl/sparse_scatter.sv
// rtl/sparse_scatter.sv - expands a compact nonzero vector into a dense vector under an occupancy mask,
// one mask bit per cycle.
module sparse_scatter
  import sparse_scatter_pkg::*;
#(
  parameter int IL     = DEF_IL,
  parameter int FL     = DEF_FL,
  parameter int LENGTH = DEF_LENGTH,
  parameter int NNZ    = DEF_NNZ
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NNZ*(IL+FL)-1:0]     c_data,
  input  logic [LENGTH-1:0]          mask,
  input  logic                       input_ready,
  input  logic                       output_taken,
  output logic [LENGTH*(IL+FL)-1:0]  d_data,
  output logic [1:0]                 state,
  output logic                       input_taken,
  output logic                       overflow,
  output logic [$clog2(NNZ):0]       nnz_count
);

  localparam int W  = IL + FL;
  localparam int MW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CW = $clog2(NNZ) + 1;

  state_e              state_q;
  logic [NNZ*W-1:0]    c_q;
  logic [LENGTH-1:0]   mask_q;
  logic [LENGTH*W-1:0] d_q;
  logic [MW-1:0]       m_ptr_q;
  logic [CW-1:0]       c_ptr_q;
  logic                overflow_q;
  logic                taken_q;

  logic [W-1:0]        c_word;
  logic                bit_set;
  logic                room;

  always_comb begin
    c_word = '0;
    for (int j = 0; j < NNZ; j++) begin
      if (c_ptr_q == CW'(j)) c_word = c_q[j*W +: W];
    end
  end

  assign bit_set = mask_q[m_ptr_q];
  assign room    = (c_ptr_q < CW'(NNZ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      c_q        <= '0;
      mask_q     <= '0;
      d_q        <= '0;
      m_ptr_q    <= '0;
      c_ptr_q    <= '0;
      overflow_q <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (input_ready) begin
            c_q        <= c_data;
            mask_q     <= mask;
            d_q        <= '0;
            m_ptr_q    <= '0;
            c_ptr_q    <= '0;
            overflow_q <= 1'b0;
            taken_q    <= 1'b1;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Positions past the compact supply are written as zero and flag overflow.
          for (int k = 0; k < LENGTH; k++) begin
            if (m_ptr_q == MW'(k)) d_q[k*W +: W] <= (bit_set && room) ? c_word : '0;
          end
          if (bit_set) begin
            if (room) c_ptr_q <= c_ptr_q + CW'(1);
            else      overflow_q <= 1'b1;
          end
          m_ptr_q <= m_ptr_q + MW'(1);
          if (m_ptr_q == MW'(LENGTH - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (output_taken) begin
            d_q        <= '0;
            overflow_q <= 1'b0;
            c_ptr_q    <= '0;
            m_ptr_q    <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign d_data      = d_q;
  assign state       = state_q;
  assign input_taken = taken_q;
  assign overflow    = overflow_q;
  assign nnz_count   = c_ptr_q;

endmodule
